// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Optional feature macro: ALU_WB_FWD_EN (youngest-entry forwarding port).
package alu_wb_pkg;

    // Default widths; match the top-level XLEN/RD_W defaults.
    localparam int DEF_XLEN = 32;
    localparam int DEF_RD_W = 5;

    // Floating-point exception flag layout {NV,DZ,OF,UF,NX}.
    localparam int FFLAG_W  = 5;
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    // Integer register x0 is hardwired to zero, so writes to it are dropped.
    localparam logic [DEF_RD_W-1:0] RD_ZERO = '0;

    // One buffered ALU result with its destination tag and flags.
    typedef struct packed {
        logic [DEF_XLEN-1:0] result;
        logic [DEF_RD_W-1:0] rd;
        logic                is_fp;
        logic [FFLAG_W-1:0]  fflags;
    } wb_entry_t;

    // Sticky flag update: a clear wipes old flags, but flags of a result
    // committed in the same cycle still land.
    function automatic logic [FFLAG_W-1:0] fflags_merge(
        input logic [FFLAG_W-1:0] acc,
        input logic               clr,
        input logic               commit,
        input logic [FFLAG_W-1:0] head_flags
    );
        return (clr ? '0 : acc) | (commit ? head_flags : '0);
    endfunction

endpackage

// File: rtl/alu_wb_stage_fifo.sv
// Generic DEPTH-entry FIFO with valid/ready on both sides.
// Handshake: a beat transfers on a rising edge when valid && ready; valid
// never depends combinationally on ready. in_ready comes from a registered
// full flag, so a full FIFO never accepts, even while it is being drained.
// Pointers wrap by compare-and-reset so any DEPTH in 2..8 works.
// Optional feature macro: ALU_WB_FWD_EN (exposes the youngest entry).
module wb_fifo
    import alu_wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  entry_t                     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output entry_t                     out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALU_WB_FWD_EN
    ,
    output logic                       young_valid,
    output entry_t                     young_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             push, pop;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = !full_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[head_q];
    assign count     = count_q;
    assign push      = in_valid && !full_q;
    assign pop       = out_valid && out_ready;

    // Next pointer, occupancy and full-flag computation.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Pointer, occupancy and full-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Entry storage; cleared on reset so wb_data/wb_rd read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[tail_q] <= in_data;
        end
    end

`ifdef ALU_WB_FWD_EN
    logic [PTR_W-1:0] young_ptr;

    // The youngest entry sits one slot behind the tail, wrapping backwards.
    always_comb begin
        young_ptr = (tail_q == '0) ? LAST : tail_q - 1'b1;
    end

    assign young_valid = out_valid;
    assign young_data  = mem_q[young_ptr];
`endif

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers ALU results, steers the commit to the integer
// or FP register file and keeps sticky FP exception flags for the CSR block.
// Handshakes: input accepted when in_valid && in_ready; head committed when
// wb_valid && wb_ready. Nothing on in_* reaches wb_* combinationally.
// Optional feature macro: ALU_WB_FWD_EN adds fwd_* outputs exposing the
// youngest buffered entry for operand forwarding.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_result,
    input  logic [RD_W-1:0]            in_rd,
    input  logic                       in_is_fp,
    input  logic [FFLAG_W-1:0]         in_fflags,
    input  logic                       wb_ready,
    output logic                       wb_valid,
    output logic [XLEN-1:0]            wb_data,
    output logic [RD_W-1:0]            wb_rd,
    output logic                       int_we,
    output logic                       fp_we,
    input  logic                       fflags_clr,
    output logic [FFLAG_W-1:0]         fflags_acc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef ALU_WB_FWD_EN
    ,
    output logic                       fwd_valid,
    output logic [RD_W-1:0]            fwd_rd,
    output logic                       fwd_is_fp,
    output logic [XLEN-1:0]            fwd_data
`endif
);

    // Same field order as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]    result;
        logic [RD_W-1:0]    rd;
        logic               is_fp;
        logic [FFLAG_W-1:0] fflags;
    } entry_t;

    localparam logic [RD_W-1:0] RD_X0 = RD_W'(RD_ZERO);

    entry_t             in_entry;
    entry_t             head;
    logic               commit;
    logic [FFLAG_W-1:0] fflags_acc_q, fflags_acc_d;

    assign in_entry = '{result: in_result, rd: in_rd, is_fp: in_is_fp, fflags: in_fflags};

`ifdef ALU_WB_FWD_EN
    logic   young_valid;
    entry_t young;
`endif

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_entry),
        .out_valid   (wb_valid),
        .out_ready   (wb_ready),
        .out_data    (head),
        .count       (occupancy)
`ifdef ALU_WB_FWD_EN
        ,
        .young_valid (young_valid),
        .young_data  (young)
`endif
    );

    assign wb_data = head.result;
    assign wb_rd   = head.rd;
    assign commit  = wb_valid && wb_ready;

    // Write-strobe decode; an x0 commit still retires and still raises flags.
    always_comb begin
        int_we = commit && !head.is_fp && (head.rd != RD_X0);
        fp_we  = commit && head.is_fp;
    end

    // Sticky flags collect at commit time, never at accept.
    always_comb begin
        fflags_acc_d = fflags_merge(fflags_acc_q, fflags_clr, commit, head.fflags);
    end

    // Accumulated flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_acc_q <= '0;
        end else begin
            fflags_acc_q <= fflags_acc_d;
        end
    end

    assign fflags_acc = fflags_acc_q;

`ifdef ALU_WB_FWD_EN
    // Forward the youngest entry; an integer x0 result is never forwarded.
    always_comb begin
        fwd_valid = young_valid && !(!young.is_fp && (young.rd == RD_X0));
        fwd_rd    = young.rd;
        fwd_is_fp = young.is_fp;
        fwd_data  = young.result;
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed vector table, a mid-stream async reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_alu_wb_stage;
    import alu_wb_pkg::*;

    localparam int XLEN  = 32;
    localparam int RD_W  = 5;
    localparam int DEPTH = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [XLEN-1:0]    in_result = '0;
    logic [RD_W-1:0]    in_rd = '0;
    logic               in_is_fp = 1'b0;
    logic [4:0]         in_fflags = '0;
    logic               wb_ready = 1'b0;
    logic               wb_valid;
    logic [XLEN-1:0]    wb_data;
    logic [RD_W-1:0]    wb_rd;
    logic               int_we;
    logic               fp_we;
    logic               fflags_clr = 1'b0;
    logic [4:0]         fflags_acc;
    logic [OCC_W-1:0]   occupancy;
`ifdef ALU_WB_FWD_EN
    logic               fwd_valid;
    logic [RD_W-1:0]    fwd_rd;
    logic               fwd_is_fp;
    logic [XLEN-1:0]    fwd_data;
`endif

    int checks = 0;
    int failures = 0;

    alu_wb_stage #(.XLEN(XLEN), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .in_is_fp   (in_is_fp),
        .in_fflags  (in_fflags),
        .wb_ready   (wb_ready),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .int_we     (int_we),
        .fp_we      (fp_we),
        .fflags_clr (fflags_clr),
        .fflags_acc (fflags_acc),
        .occupancy  (occupancy)
`ifdef ALU_WB_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_is_fp  (fwd_is_fp),
        .fwd_data   (fwd_data)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] res, input logic [4:0] rd,
                         input logic fp, input logic [4:0] ff, input logic wr, input logic clr);
        in_valid   = iv;
        in_result  = res;
        in_rd      = rd;
        in_is_fp   = fp;
        in_fflags  = ff;
        wb_ready   = wr;
        fflags_clr = clr;
    endtask

    // Directed vector: one row per cycle, expectations observed before the edge.
    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        fp;
        logic [4:0]  ff;
        logic        wr;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_int;
        logic        e_fp;
        logic [4:0]  e_acc;
        logic [1:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [31:0] res, logic [4:0] rd, logic fp,
                                logic [4:0] ff, logic wr, logic clr, logic e_valid,
                                logic [31:0] e_data, logic [4:0] e_rd, logic e_int,
                                logic e_fp, logic [4:0] e_acc, logic [1:0] e_occ, logic e_rdy);
        vec_t v;
        v.iv = iv; v.res = res; v.rd = rd; v.fp = fp; v.ff = ff; v.wr = wr; v.clr = clr;
        v.e_valid = e_valid; v.e_data = e_data; v.e_rd = e_rd; v.e_int = e_int;
        v.e_fp = e_fp; v.e_acc = e_acc; v.e_occ = e_occ; v.e_rdy = e_rdy;
        return v;
    endfunction

    vec_t vecs[20];

    // Reference model state.
    wb_entry_t  mq[$];
    logic [4:0] m_acc;

    initial begin
        logic [4:0] nv, of, uf, nx;
        nv = '0; of = '0; uf = '0; nx = '0;
        nv[FFLAG_NV] = 1'b1;
        of[FFLAG_OF] = 1'b1;
        uf[FFLAG_UF] = 1'b1;
        nx[FFLAG_NX] = 1'b1;

        //            iv  res           rd fp ff       wr clr | val data          rd int fp acc       occ rdy
        // single op
        vecs[0]  = mk(1, 32'h0000_002A, 5, 0, 0,       1, 0,   0, 0,            0, 0, 0, 0,       0, 1);
        vecs[1]  = mk(0, 0,             0, 0, 0,       1, 0,   1, 32'h2A,       5, 1, 0, 0,       1, 1);
        vecs[2]  = mk(0, 0,             0, 0, 0,       1, 0,   0, 0,            0, 0, 0, 0,       0, 1);
        // back-pressure and full
        vecs[3]  = mk(1, 32'h11,        1, 0, 0,       0, 0,   0, 0,            0, 0, 0, 0,       0, 1);
        vecs[4]  = mk(1, 32'h22,        2, 0, 0,       0, 0,   1, 32'h11,       1, 0, 0, 0,       1, 1);
        vecs[5]  = mk(1, 32'h33,        3, 0, 0,       0, 0,   1, 32'h11,       1, 0, 0, 0,       2, 0);
        vecs[6]  = mk(1, 32'h33,        3, 0, 0,       1, 0,   1, 32'h11,       1, 1, 0, 0,       2, 0);
        vecs[7]  = mk(1, 32'h33,        3, 0, 0,       1, 0,   1, 32'h22,       2, 1, 0, 0,       1, 1);
        vecs[8]  = mk(0, 0,             0, 0, 0,       1, 0,   1, 32'h33,       3, 1, 0, 0,       1, 1);
        vecs[9]  = mk(0, 0,             0, 0, 0,       1, 0,   0, 0,            0, 0, 0, 0,       0, 1);
        // x0 suppression, flags still accumulate
        vecs[10] = mk(1, 32'hFFFF_FFFF, 0, 0, nv,      1, 0,   0, 0,            0, 0, 0, 0,       0, 1);
        vecs[11] = mk(0, 0,             0, 0, 0,       1, 0,   1, 32'hFFFF_FFFF, 0, 0, 0, 0,      1, 1);
        vecs[12] = mk(0, 0,             0, 0, 0,       1, 1,   0, 0,            0, 0, 0, nv,      0, 1);
        // FP steering, f0 writable
        vecs[13] = mk(1, 32'h3F80_0000, 0, 1, nx,      1, 0,   0, 0,            0, 0, 0, 0,       0, 1);
        vecs[14] = mk(1, 32'h4000_0000, 3, 1, of | nx, 1, 0,   1, 32'h3F80_0000, 0, 0, 1, 0,      1, 1);
        vecs[15] = mk(0, 0,             0, 0, 0,       1, 0,   1, 32'h4000_0000, 3, 0, 1, nx,     1, 1);
        vecs[16] = mk(0, 0,             0, 0, 0,       1, 0,   0, 0,            0, 0, 0, of | nx, 0, 1);
        // clear colliding with a commit
        vecs[17] = mk(1, 32'h7,         7, 0, uf,      1, 0,   0, 0,            0, 0, 0, of | nx, 0, 1);
        vecs[18] = mk(0, 0,             0, 0, 0,       1, 1,   1, 32'h7,        7, 1, 0, of | nx, 1, 1);
        vecs[19] = mk(0, 0,             0, 0, 0,       1, 0,   0, 0,            0, 0, 0, uf,      0, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_fflags_acc", fflags_acc, 0);
        chk("reset_wb_data", wb_data, 0);
        chk("reset_wb_rd", wb_rd, 0);

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].res, vecs[i].rd, vecs[i].fp, vecs[i].ff,
                  vecs[i].wr, vecs[i].clr);
            #1;
            chk($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].e_data);
                chk($sformatf("vec%0d_wb_rd", i), wb_rd, vecs[i].e_rd);
            end
            chk($sformatf("vec%0d_int_we", i), int_we, vecs[i].e_int);
            chk($sformatf("vec%0d_fp_we", i), fp_we, vecs[i].e_fp);
            chk($sformatf("vec%0d_fflags_acc", i), fflags_acc, vecs[i].e_acc);
            chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            @(posedge clk);
        end

        // Async reset with two entries held and flags accumulated.
        @(negedge clk);
        drive(1, 32'hA1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 32'hA2, 2, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_reset_occupancy", occupancy, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_wb_valid", wb_valid, 0);
        chk("mid_reset_occupancy", occupancy, 0);
        chk("mid_reset_fflags_acc", fflags_acc, 0);
        wb_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_reset_wb_valid", wb_valid, 0);
            chk("post_reset_int_we", int_we, 0);
            chk("post_reset_fp_we", fp_we, 0);
            chk("post_reset_in_ready", in_ready, 1);
            chk("post_reset_occupancy", occupancy, 0);
            @(negedge clk);
        end

        // Randomized traffic against the queue model (starts empty, no flags).
        m_acc = '0;
        mq.delete();
        for (int n = 0; n < 3000; n++) begin
            wb_entry_t  hd, yg, nw;
            logic       e_valid, e_rdy, commit, accept;
            logic       iv, wr, clr;

            iv  = ($urandom_range(0, 9) < 6);
            wr  = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 7) == 0);
            nw.result = $urandom;
            nw.rd     = 5'($urandom_range(0, 3));
            nw.is_fp  = $urandom_range(0, 1);
            nw.fflags = 5'($urandom_range(0, 31));

            @(negedge clk);
            drive(iv, nw.result, nw.rd, nw.is_fp, nw.fflags, wr, clr);
            #1;
            e_valid = (mq.size() > 0);
            e_rdy   = (mq.size() < DEPTH);
            hd      = e_valid ? mq[0] : '0;
            chk("rnd_wb_valid", wb_valid, e_valid);
            chk("rnd_in_ready", in_ready, e_rdy);
            chk("rnd_occupancy", occupancy, mq.size());
            chk("rnd_fflags_acc", fflags_acc, m_acc);
            if (e_valid) begin
                chk("rnd_wb_data", wb_data, hd.result);
                chk("rnd_wb_rd", wb_rd, hd.rd);
            end
            chk("rnd_int_we", int_we, e_valid && wr && !hd.is_fp && (hd.rd != 0));
            chk("rnd_fp_we", fp_we, e_valid && wr && hd.is_fp);
`ifdef ALU_WB_FWD_EN
            yg = e_valid ? mq[$] : '0;
            chk("rnd_fwd_valid", fwd_valid, e_valid && !(!yg.is_fp && yg.rd == 0));
            if (e_valid && !(!yg.is_fp && yg.rd == 0)) begin
                chk("rnd_fwd_data", fwd_data, yg.result);
                chk("rnd_fwd_rd", fwd_rd, yg.rd);
                chk("rnd_fwd_is_fp", fwd_is_fp, yg.is_fp);
            end
`else
            yg = '0;
`endif
            @(posedge clk);
            commit = e_valid && wr;
            accept = iv && e_rdy;
            m_acc  = (clr ? 5'b0 : m_acc) | (commit ? hd.fflags : 5'b0);
            if (commit) void'(mq.pop_front());
            if (accept) mq.push_back(nw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the FP/integer ALU and float-to-int conversion stage.
- Registers each ALU result (out_alu) with its destination tag, and buffers it in a small FIFO so the ALU never loses a result when the register-file write port stalls.
- Steers the commit to the integer or FP register file and accumulates sticky FP exception flags (fflags) for the CSR block.

Parameters:
- XLEN, 32, result width (matches ALU out_alu).
- RD_W, 5, register index width.
- DEPTH, 2, buffer entries (2 = skid buffer); legal values 2..8, power of two not required.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; high when fewer than DEPTH entries are occupied.
- in_result  in  XLEN  ALU/conversion result.
- in_rd  in  RD_W  destination register index.
- in_is_fp  in  1  1 = FP register file, 0 = integer file (conversions write integer).
- in_fflags  in  5  exception flags {NV,DZ,OF,UF,NX} for this result.
- wb_ready  in  1  register-file write port free this cycle.
- wb_valid  out  1  head entry valid.
- wb_data  out  XLEN  head entry result.
- wb_rd  out  RD_W  head entry destination.
- int_we  out  1  integer register-file write strobe.
- fp_we  out  1  FP register-file write strobe.
- fflags_clr  in  1  CSR write clears accumulated flags.
- fflags_acc  out  5  sticky accumulated flags.
- occupancy  out  $clog2(DEPTH+1)  entries held.

Behaviour:
- Reset (asynchronous, rst_n low): all entries are invalidated, and occupancy, wb_valid, int_we, fp_we and fflags_acc go to 0. wb_data and wb_rd go to 0. in_ready goes to 1 once rst_n is deasserted. Any in-flight results are discarded.
- Input handshake: an entry is accepted on a rising edge when in_valid && in_ready. The entry is written at the tail pointer.
- Output handshake: the head entry is committed on a rising edge when wb_valid && wb_ready. The head pointer then advances.
- Latency: an entry accepted at edge N appears on wb_* after edge N, i.e. it is visible in cycle N+1. There is no combinational path from in_* to wb_*.
- FIFO ordering: strict FIFO. Head and tail pointers wrap modulo DEPTH. Pointer arithmetic is correct for non-power-of-two DEPTH, using an explicit compare-and-reset rather than bit truncation.
- Full: occupancy == DEPTH forces in_ready = 0. If in_valid is high while full, the input is ignored; the upstream must hold it.
- Simultaneous accept and commit when full: in_ready is still 0 (registered full flag), so no accept happens that cycle.
- Simultaneous accept and commit when not full: occupancy is unchanged, and both pointers advance.
- Empty: wb_valid = 0, and int_we and fp_we are 0.
- Write strobes:
  - int_we = wb_valid && wb_ready && !is_fp && (wb_rd != 0). The x0 write is suppressed, but the entry still commits and its flags still accumulate.
  - fp_we = wb_valid && wb_ready && is_fp. FP register f0 is writable.
- Flag accumulation, per edge:
  - fflags_acc_next = (fflags_clr ? 0 : fflags_acc) | (commit ? head_fflags : 0).
  - Flags of a result committed in the same cycle as a clear survive.
  - Flags accumulate at commit, not at accept.
- rst_n asserted mid-transfer: takes effect immediately, regardless of the handshake state.

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (RD_W), fwd_is_fp (1) and fwd_data (XLEN). These expose the youngest valid entry (tail-1) for operand forwarding into the ALU's read_data1/read_data2 muxes. fwd_valid = occupancy != 0. An integer forward with rd == 0 forces fwd_valid = 0.
- Undefined: the ports do not exist and no youngest-entry logic is generated.

Decomposition:
- Shared package alu_wb_pkg:
  - typedef wb_entry_t {result, rd, is_fp, fflags}.
  - Flag bit-index constants FFLAG_NV..FFLAG_NX.
  - Localparam RD_ZERO.
- One natural sub-module: wb_fifo, a generic parameterised DEPTH-entry FIFO of wb_entry_t with valid/ready on both sides and an occupancy output.
- The top level adds the strobe decode and the flag accumulator.

Test Plan:
1. Reset then single op: in_result=0x0000_002A, rd=5, int, wb_ready=1 -> next cycle wb_valid=1 and int_we=1 with wb_data=0x2A, wb_rd=5; occupancy returns to 0.
2. Back-pressure/full: hold wb_ready=0 and push 3 results (0x11, 0x22, 0x33) -> the first two are accepted, in_ready drops after the 2nd, and 0x33 is held. Then release wb_ready -> commits occur in the order 0x11, 0x22, 0x33, with no loss or duplication.
3. x0 suppression: int result 0xFFFF_FFFF with rd=0 and in_fflags=NV -> the entry commits with int_we=0, and fflags_acc=5'b10000.
4. FP steer and flags: fp result with rd=0 and fflags=NX, then fp result with rd=3 and fflags=OF|NX -> fp_we pulses twice, and fflags_acc=5'b00101.
5. Clear collision: fflags_clr=1 in the same cycle as a commit carrying UF -> fflags_acc=5'b00010; all previously accumulated flags are gone.
6. Async reset mid-stream: assert rst_n=0 between clock edges with 2 entries held -> wb_valid and occupancy go to 0 immediately, and no write strobe fires after release.
